isqrt_seq: RTL and testbench

- Iterative integer square-root responder serving the isqrt request/response interface that the formula FSMs drive: y = floor(sqrt(x)).
- One calculation in flight at a time; result bits are produced K per clock.
- Sits as the single shared isqrt instance behind a formula FSM.
- Accepts a new request in the same cycle it presents a result, so FSM chains run back-to-back.

---
 rtl/isqrt_seq_pkg.sv | 21 ++
 rtl/isqrt_step.sv | 24 ++
 rtl/isqrt_seq.sv | 112 +++++++++++
 tb/tb_isqrt_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_seq_pkg.sv
// Shared types and sizing helpers for the sequential integer square root.
package isqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N_DEFAULT = 32;
  localparam int unsigned K_DEFAULT = 1;

  function automatic int unsigned res_width(input int unsigned n);
    return n / 2;
  endfunction

  function automatic int unsigned latency(input int unsigned n, input int unsigned k);
    return (n / 2) / k;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
module isqrt_step #(
  parameter int unsigned RES_W = 16
) (
  input  logic [RES_W+1:0] rem_i,
  input  logic [RES_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [RES_W+1:0] rem_o,
  output logic [RES_W-1:0] root_o
);

  logic [RES_W+1:0] rem_sh;
  logic [RES_W+1:0] trial;
  logic             ge;

  always_comb begin
    rem_sh = (rem_i << 2) | {{RES_W{1'b0}}, bits_i};
    trial  = {root_i, 2'b01};
    ge     = (rem_sh >= trial);
    rem_o  = ge ? (rem_sh - trial) : rem_sh;
    root_o = (root_i << 1) | {{(RES_W-1){1'b0}}, ge};
  end

endmodule

// File: rtl/isqrt_seq.sv
// Iterative floor(sqrt(x)) responder, K result bits per clock, one request in flight.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned K = K_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_vld,
  input  logic [N-1:0]     x,
  output logic             x_rdy,
  output logic             y_vld,
  output logic [N/2-1:0]   y
);

  localparam int unsigned RES_W = res_width(N);
  localparam int unsigned REM_W = RES_W + 2;
  localparam int unsigned L     = latency(N, K);
  localparam int unsigned CNT_W = (L > 1) ? $clog2(L) : 1;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [RES_W-1:0]   root_q, root_d;
  logic [N-1:0]       op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   y_q, y_d;

  logic               accept;
  logic [REM_W-1:0]   rem_c  [K+1];
  logic [RES_W-1:0]   root_c [K+1];
  logic [N-1:0]       op_c   [K+1];

  assign x_rdy  = (state_q == IDLE) | (state_q == DONE);
  assign accept = x_rdy & x_vld;
  assign y_vld  = (state_q == DONE);
  assign y      = y_q;

  // The accepting edge already runs the first K iterations on a fresh
  // (rem=0, root=0, operand=x) context, so the result lands L edges later.
  assign rem_c[0]  = accept ? '0 : rem_q;
  assign root_c[0] = accept ? '0 : root_q;
  assign op_c[0]   = accept ? x  : op_q;

  for (genvar j = 0; j < K; j++) begin : g_step
    isqrt_step #(.RES_W(RES_W)) u_step (
      .rem_i  (rem_c[j]),
      .root_i (root_c[j]),
      .bits_i (op_c[j][N-1:N-2]),
      .rem_o  (rem_c[j+1]),
      .root_o (root_c[j+1])
    );
    assign op_c[j+1] = op_c[j] << 2;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    root_d  = root_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE, DONE: begin
        if (x_vld) begin
          rem_d  = rem_c[K];
          root_d = root_c[K];
          op_d   = op_c[K];
          if (L == 1) begin
            state_d = DONE;
            y_d     = root_c[K];
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(L - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        rem_d  = rem_c[K];
        root_d = root_c[K];
        op_d   = op_c[K];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          y_d     = root_c[K];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      root_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Randomized and directed check of isqrt_seq against a binary-search square-root model.
module tb_isqrt_seq;

  localparam int unsigned N_RAND = 1500;
  localparam int unsigned SW_N   = 1500;

  logic        clk;
  logic        rst_n;
  logic        rst_sw_n;
  logic        x_vld;
  logic [31:0] x;
  logic        x_rdy;
  logic        y_vld;
  logic [15:0] y;

  int n_cmp;
  int n_err;
  int sw_fin;

  isqrt_seq #(.N(32), .K(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld),
    .x     (x),
    .x_rdy (x_rdy),
    .y_vld (y_vld),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= v, found by binary search on 64-bit products.
  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return 16'(lo);
  endfunction

  task automatic accept(input logic [31:0] xv);
    int t;
    t = 0;
    while (!x_rdy && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check_eq("accept_rdy", 64'(x_rdy), 64'd1);
    x     = xv;
    x_vld = 1'b1;
    @(posedge clk); #1;
    x_vld = 1'b0;
    x     = $urandom;
  endtask

  // Called #1 after an edge; lat0 is the cycle index (counted from acceptance) of that point.
  task automatic wait_y(input int lat0, input int lat_exp, input logic [15:0] y_exp, input string tag);
    int lat;
    lat = lat0;
    while (!y_vld && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check_eq({tag, "_y"}, 64'(y), 64'(y_exp));
    check_eq({tag, "_rdy"}, 64'(x_rdy), 64'd1);
  endtask

  task automatic single(input logic [31:0] xv, input logic [15:0] y_exp, input string tag);
    accept(xv);
    wait_y(1, 16, y_exp, tag);
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 64'(y_vld), 64'd0);
    check_eq({tag, "_hold"}, 64'(y), 64'(y_exp));
  endtask

  for (genvar g = 1; g <= 4; g++) begin : g_sw
    localparam int unsigned KS = 1 << g;
    localparam int unsigned LS = 16 / KS;
    logic        v, r, yv;
    logic [31:0] xs;
    logic [15:0] ys;

    isqrt_seq #(.N(32), .K(KS)) u_sw (
      .clk   (clk),
      .rst_n (rst_sw_n),
      .x_vld (v),
      .x     (xs),
      .x_rdy (r),
      .y_vld (yv),
      .y     (ys)
    );

    initial begin
      v  = 1'b0;
      xs = '0;
      @(posedge rst_sw_n);
      @(posedge clk); #1;
      for (int i = 0; i < int'(SW_N); i++) begin
        logic [31:0] xv;
        int lat;
        xv = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'd0 : $urandom;
        check_eq($sformatf("sw_k%0d_rdy", KS), 64'(r), 64'd1);
        xs = xv;
        v  = 1'b1;
        @(posedge clk); #1;
        v  = 1'b0;
        xs = $urandom;
        lat = 1;
        while (!yv && lat < 40) begin
          @(posedge clk); #1; lat++;
        end
        check_eq($sformatf("sw_k%0d_lat", KS), 64'(lat), 64'(LS));
        check_eq($sformatf("sw_k%0d_y x=%0h", KS, xv), 64'(ys), 64'(ref_isqrt(xv)));
      end
      sw_fin++;
    end
  end

  initial begin
    int cnt, t;
    n_cmp    = 0;
    n_err    = 0;
    sw_fin   = 0;
    rst_n    = 1'b0;
    rst_sw_n = 1'b0;
    x_vld    = 1'b0;
    x        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_y_vld", 64'(y_vld), 64'd0);
    check_eq("rst_y", 64'(y), 64'd0);
    check_eq("rst_x_rdy", 64'(x_rdy), 64'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(posedge clk); #1;

    single(32'd0, 16'd0, "x0");
    single(32'd1, 16'd1, "x1");
    single(32'd15, 16'd3, "x15");
    single(32'd16, 16'd4, "x16");
    single(32'd1000000, 16'd1000, "x1e6");
    single(32'hFFFF_FFFF, 16'hFFFF, "xmax");

    // Formula-FSM style chain: next request issued in the result cycle.
    accept(32'd16);
    wait_y(1, 16, 16'd4, "chain0");
    accept(32'd4 + 32'd12);
    wait_y(1, 16, 16'd4, "chain1");
    accept(32'd4 + 32'd5);
    wait_y(1, 16, 16'd3, "chain2");
    @(posedge clk); #1;
    check_eq("chain_pulse", 64'(y_vld), 64'd0);

    // A request offered while busy is a protocol violation and must be dropped.
    accept(32'd100);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("busy_rdy", 64'(x_rdy), 64'd0);
    x_vld = 1'b1;
    x     = 32'd49;
    @(posedge clk); #1;
    x_vld = 1'b0;
    wait_y(6, 16, 16'd10, "busy");
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (y_vld) cnt++;
    end
    check_eq("busy_second_y", 64'(cnt), 64'd0);

    accept(32'd500);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_y_vld", 64'(y_vld), 64'd0);
    check_eq("arst_y", 64'(y), 64'd0);
    check_eq("arst_x_rdy", 64'(x_rdy), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (y_vld) cnt++;
    end
    check_eq("arst_no_y", 64'(cnt), 64'd0);
    check_eq("arst_rdy_after", 64'(x_rdy), 64'd1);
    single(32'd81, 16'd9, "x81");

    for (int i = 0; i < int'(N_RAND); i++) begin
      logic [31:0] xv;
      logic [15:0] rr;
      rr = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       xv = $urandom;
        1:       xv = 32'(rr) * 32'(rr);
        2:       xv = 32'(rr) * 32'(rr) - 32'd1;
        default: xv = 32'($urandom_range(0, 300));
      endcase
      accept(xv);
      wait_y(1, 16, ref_isqrt(xv), $sformatf("rand x=%0h", xv));
    end

    t = 0;
    while (sw_fin < 4 && t < 60000) begin
      @(posedge clk); t++;
    end
    check_eq("sweep_done", 64'(sw_fin), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
